// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch/decode constants and the next-PC select encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_INCR          = 32'd4;
    localparam logic [WORD_W-1:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] npc_sel_t;

    localparam npc_sel_t NPC_SEQ = 2'd0;
    localparam npc_sel_t NPC_BR  = 2'd1;
    localparam npc_sel_t NPC_J   = 2'd2;
    localparam npc_sel_t NPC_JR  = 2'd3;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_module_if_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with write enable and flush-to-NOP.
// Revision : 1.0
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] npc_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] npc_o
);

    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] npc_q;
    logic [WORD_W-1:0] instr_d;
    logic [WORD_W-1:0] npc_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        if (we_i) begin
            if (flush_i) begin
                instr_d = NOP_INSTR;
                npc_d   = '0;
            end else begin
                instr_d = instr_i;
                npc_d   = npc_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/cpu_module_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_module_if
// Brief    : Instruction-fetch stage: PC, next-PC select, IF/ID register.
// Revision : 1.0
// ============================================================================
module cpu_module_if
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_IFWrite,
    input  logic              Z,
    input  logic              J_Valid,
    input  logic              JR_Valid,
    input  logic [WORD_W-1:0] BranchAddr,
    input  logic [WORD_W-1:0] JAddr,
    input  logic [WORD_W-1:0] JRAddr,
    input  logic [WORD_W-1:0] IMemData,
    output logic [WORD_W-1:0] IMemAddr,
    output logic [WORD_W-1:0] PC_if,
    output logic [WORD_W-1:0] Instruction_id,
    output logic [WORD_W-1:0] NextPC_id,
    output logic [WORD_W-1:0] FetchCount
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] cnt_d;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] target;
    logic              redirect;
    npc_sel_t          npc_sel;

    assign pc_plus4 = pc_q + PC_INCR;
    assign redirect = JR_Valid | J_Valid | Z;

    always_comb begin
        npc_sel = NPC_SEQ;
        if (JR_Valid) begin
            npc_sel = NPC_JR;
        end else if (J_Valid) begin
            npc_sel = NPC_J;
        end else if (Z) begin
            npc_sel = NPC_BR;
        end
    end

    always_comb begin
        target = pc_plus4;
        case (npc_sel)
            NPC_JR:  target = JRAddr;
            NPC_J:   target = JAddr;
            NPC_BR:  target = BranchAddr;
            default: target = pc_plus4;
        endcase
    end

    // Redirect inputs are only looked at when the stage is allowed to advance,
    // so garbage on them during a stall cannot leak into state.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (PC_IFWrite) begin
            pc_d = align_word(target);
            if (!redirect) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= align_word(RESET_PC);
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .we_i    (PC_IFWrite),
        .flush_i (redirect),
        .instr_i (IMemData),
        .npc_i   (pc_plus4),
        .instr_o (Instruction_id),
        .npc_o   (NextPC_id)
    );

    assign IMemAddr   = pc_q;
    assign PC_if      = pc_q;
    assign FetchCount = cnt_q;

endmodule : cpu_module_if
`default_nettype wire
